demux_1_n_stream: RTL and testbench
===================================

Name: demux_1_n_stream

Overview:
- Parametrised, registered 1-to-N stream demultiplexer: the next generation of the combinational 1:4 demux.
- Routes one DATA_W word per transfer from a valid/ready input to one selected output channel, or to all channels in broadcast mode.
- Holds each word in a single-entry output register until every targeted channel has handshaken.
- Out-of-range selects are dropped and counted.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- N_OUT, 4, number of output channels (2..16)
- DATA_W, 8, data word width
- SEL_W, $clog2(N_OUT) (minimum 1), width of the channel select
- CNT_W, 8, width of the saturating drop counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  DATA_W  input word
- in_sel  input  SEL_W  destination channel
- in_bcast  input  1  1 = deliver to all N_OUT channels; in_sel ignored
- out_valid  output  N_OUT  per-channel valid (bit i = channel i)
- out_ready  input  N_OUT  per-channel ready
- out_data  output  DATA_W  held word, common to all channels
- busy  output  1  any delivery pending (OR of out_valid)
- drop_cnt  output  CNT_W  count of dropped out-of-range words, saturating
- drop_pulse  output  1  one-cycle pulse on each drop

Behaviour:
- Reset: asynchronous, active-high, on clk and rst only. Sets pend = 0, out_data = 0, drop_cnt = 0, drop_pulse = 0. Consequently out_valid = 0, busy = 0, in_ready = 1.
- Reset mid-delivery discards the held word. No partial broadcast completion is reported.
- State: pend[N_OUT-1:0] (out_valid = pend), data register, drop counter.
- Channel handshake: bit i clears on an edge where out_valid[i] && out_ready[i]. Channels clear independently.
- Clear mask: done = pend & out_ready (combinational).
- in_ready = ((pend & ~out_ready) == 0). The block accepts when the buffer is empty or empties this cycle. This is a combinational out_ready->in_ready path and gives full throughput of 1 word/cycle.
- Accept = in_valid && in_ready. On the accepting edge:
  - in_bcast = 1: pend <= all ones; data <= in_data.
  - in_bcast = 0, in_sel < N_OUT: pend <= onehot(in_sel); data <= in_data.
  - in_bcast = 0, in_sel >= N_OUT (only possible when N_OUT is not a power of 2): word dropped; pend <= 0; data unchanged; drop_pulse <= 1; drop_cnt <= drop_cnt + 1, saturating at all ones.
- No accept: pend <= pend & ~done; drop_pulse <= 0.
- Latency: a word accepted at edge k shows out_valid at edge k (registered); the earliest downstream handshake is edge k+1.
- Simultaneous events: final handshake of the old word plus a new accept in the same cycle means the new pend mask replaces the old one; no bubble.
- A broadcast completes only when every bit has cleared. Slow channels stall the input; fast channels do not see the word twice.
- out_data is stable while busy = 1. Consumers must ignore it when their out_valid bit is 0.
- in_data and in_sel are don't-care when in_valid = 0. No X may propagate into pend from an idle input.

Decomposition:
- Shared package demux_pkg:
  - function onehot(sel, N) returning an N_OUT-bit mask
  - localparam for SEL_W computation
  - CNT_W default
- One natural sub-module: sat_counter (CNT_W, inc, rst -> count), used for drop_cnt. The team's other blocks reuse it.
- Everything else is inline.

Test Plan:
- Reset with N_OUT=4, DATA_W=8, in_valid=1 held during rst -> out_valid=0000, busy=0, drop_cnt=0, in_ready=1; no accept while rst=1.
- Unicast sweep: in_data=A5, in_sel=0,1,2,3 on consecutive cycles, out_ready=1111 -> out_valid=0001, 0010, 0100, 1000 on successive cycles; out_data=A5; in_ready stays 1.
- Backpressure: in_sel=2, out_ready[2]=0 for 3 cycles -> out_valid=0100 held; in_ready=0 for those 3 cycles; second word waits; first handshake on the cycle out_ready[2] rises.
- Broadcast: in_bcast=1, data=3C; out_ready toggled to ack ch0 at cycle 1, ch3 at cycle 2, ch1+ch2 at cycle 4 -> out_valid = 1111, 1110, 0110, 0110, 0000; in_ready rises only in cycle 4.
- Drop: N_OUT=3, in_sel=3, 300 drops -> drop_pulse high each time; pend stays 000; drop_cnt saturates at 255.
- Async reset asserted mid-broadcast with out_valid=0110 -> out_valid=000 immediately, without waiting for a clk edge; next accept after release behaves normally.

Source files
------------

// File: rtl/demux_1_n_stream_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer family.
// Holds the select-width rule, the drop-counter default width and the one-hot decoder.
package demux_pkg;

  localparam int MAX_OUT       = 16;
  localparam int MAX_SEL_W     = 4;
  localparam int CNT_W_DEFAULT = 8;

  // The select needs at least one bit, even when only two channels exist.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] sel, input int n);
    logic [MAX_OUT-1:0] mask;
    mask = {MAX_OUT{1'b0}};
    for (int i = 0; i < MAX_OUT; i++) begin
      if ((i < n) && (sel == i[MAX_SEL_W-1:0])) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/demux_1_n_stream_if.sv
// Producer/consumer bundle of the stream demux; slave is the demux side,
// master is the side that feeds the producer and the N consumers.
interface demux_1_n_stream_if
  import demux_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_width(N_OUT),
  parameter int CNT_W  = CNT_W_DEFAULT
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_bcast;
  logic [N_OUT-1:0]  out_valid;
  logic [N_OUT-1:0]  out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic [CNT_W-1:0]  drop_cnt;
  logic              drop_pulse;

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, busy, drop_cnt, drop_pulse
  );

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, busy, drop_cnt, drop_pulse
  );

endinterface

// File: rtl/demux_1_n_stream_sat_counter.sv
// Saturating up-counter: advances by one per cycle with inc high and sticks at all ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/demux_1_n_stream.sv
// Registered 1-to-N stream demux: one held word, per-channel pending mask,
// unicast or broadcast delivery, out-of-range selects dropped and counted.
module demux_1_n_stream
  import demux_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_width(N_OUT),
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1_n_stream_if.slave    bus
);

  logic [N_OUT-1:0]     pend_q;
  logic [N_OUT-1:0]     pend_d;
  logic [DATA_W-1:0]    data_q;
  logic [DATA_W-1:0]    data_d;
  logic                 drop_pulse_q;
  logic                 drop_pulse_d;

  logic [N_OUT-1:0]     done_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic [MAX_SEL_W-1:0] sel_ext_s;
  logic                 in_range_s;
  logic [MAX_OUT-1:0]   onehot_s;
  logic                 onehot_unused_s;
  logic                 drop_s;

  assign done_s     = pend_q & bus.out_ready;
  // Ready looks through this cycle's handshakes so a draining buffer refills without a bubble.
  assign in_ready_s = ((pend_q & ~bus.out_ready) == {N_OUT{1'b0}});
  assign accept_s   = bus.in_valid && in_ready_s;
  assign sel_ext_s  = MAX_SEL_W'(bus.in_sel);
  assign in_range_s = ({1'b0, sel_ext_s} < 5'(N_OUT));
  assign onehot_s   = onehot(sel_ext_s, N_OUT);
  assign onehot_unused_s = ^onehot_s;
  assign drop_s     = accept_s && !bus.in_bcast && !in_range_s;

  always_comb begin
    pend_d       = pend_q & ~done_s;
    data_d       = data_q;
    drop_pulse_d = 1'b0;
    if (accept_s) begin
      if (bus.in_bcast) begin
        pend_d = {N_OUT{1'b1}};
        data_d = bus.in_data;
      end else if (in_range_s) begin
        pend_d = onehot_s[N_OUT-1:0];
        data_d = bus.in_data;
      end else begin
        pend_d       = {N_OUT{1'b0}};
        drop_pulse_d = 1'b1;
      end
    end else begin
      drop_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= {N_OUT{1'b0}};
      data_q       <= {DATA_W{1'b0}};
      drop_pulse_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      data_q       <= data_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_s),
    .count (bus.drop_cnt)
  );

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = pend_q;
  assign bus.out_data   = data_q;
  assign bus.busy       = |pend_q;
  assign bus.drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Directed bench for demux_1_n_stream: a 4-channel instance for routing,
// backpressure, broadcast and async reset, and a 3-channel instance for drops.
module tb_demux_1_n_stream;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  demux_1_n_stream_if #(.N_OUT(4), .DATA_W(8), .SEL_W(2), .CNT_W(8)) b4 ();
  demux_1_n_stream_if #(.N_OUT(3), .DATA_W(8), .SEL_W(2), .CNT_W(8)) b3 ();

  demux_1_n_stream #(.N_OUT(4), .DATA_W(8), .SEL_W(2), .CNT_W(8)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  demux_1_n_stream #(.N_OUT(3), .DATA_W(8), .SEL_W(2), .CNT_W(8)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    n_checks = 0;
    n_errors = 0;

    b4.in_valid = 1'b1; b4.in_data = 8'hA5; b4.in_sel = 2'd0; b4.in_bcast = 1'b0;
    b4.out_ready = 4'b0000;
    b3.in_valid = 1'b0; b3.in_data = 8'h00; b3.in_sel = 2'd0; b3.in_bcast = 1'b0;
    b3.out_ready = 3'b000;
    rst = 1'b1;

    // Reset held with a valid word offered: nothing may be accepted.
    tick(); tick(); tick();
    check_eq("rst_out_valid", 32'(b4.out_valid), 32'h0);
    check_eq("rst_busy",      32'(b4.busy),      32'h0);
    check_eq("rst_drop_cnt",  32'(b4.drop_cnt),  32'h0);
    check_eq("rst_in_ready",  32'(b4.in_ready),  32'h1);
    check_eq("rst_out_data",  32'(b4.out_data),  32'h0);
    check_eq("rst3_drop_cnt", 32'(b3.drop_cnt),  32'h0);
    b4.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check_eq("post_rst_idle", 32'(b4.out_valid), 32'h0);

    // Unicast sweep at full throughput.
    b4.out_ready = 4'b1111;
    b4.in_valid  = 1'b1;
    b4.in_data   = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      b4.in_sel = 2'(i);
      check_eq("uni_in_ready", 32'(b4.in_ready), 32'h1);
      tick();
      check_eq("uni_out_valid", 32'(b4.out_valid), 32'(4'b0001 << i));
      check_eq("uni_out_data",  32'(b4.out_data),  32'hA5);
    end
    b4.in_valid = 1'b0;
    tick();
    check_eq("uni_drain", 32'(b4.out_valid), 32'h0);
    check_eq("uni_busy",  32'(b4.busy),      32'h0);

    // Backpressure on channel 2 stalls the second word.
    b4.out_ready = 4'b1011;
    b4.in_valid  = 1'b1;
    b4.in_data   = 8'h11;
    b4.in_sel    = 2'd2;
    tick();
    b4.in_data = 8'h22;
    b4.in_sel  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_out_valid", 32'(b4.out_valid), 32'h4);
      check_eq("bp_in_ready",  32'(b4.in_ready),  32'h0);
      check_eq("bp_out_data",  32'(b4.out_data),  32'h11);
      check_eq("bp_busy",      32'(b4.busy),      32'h1);
      tick();
    end
    check_eq("bp_held", 32'(b4.out_valid), 32'h4);
    b4.out_ready = 4'b1111;
    #1;
    check_eq("bp_release_ready", 32'(b4.in_ready), 32'h1);
    tick();
    check_eq("bp_second_valid", 32'(b4.out_valid), 32'h1);
    check_eq("bp_second_data",  32'(b4.out_data),  32'h22);
    b4.in_valid = 1'b0;
    tick();
    check_eq("bp_drain", 32'(b4.out_valid), 32'h0);

    // Broadcast with staggered acknowledgements.
    b4.out_ready = 4'b0000;
    b4.in_valid  = 1'b1;
    b4.in_bcast  = 1'b1;
    b4.in_sel    = 2'bxx;
    b4.in_data   = 8'h3C;
    tick();
    b4.in_valid = 1'b0;
    b4.in_bcast = 1'b0;
    b4.in_data  = 8'hxx;
    check_eq("bc_c0_valid", 32'(b4.out_valid), 32'hF);
    check_eq("bc_c0_data",  32'(b4.out_data),  32'h3C);
    b4.out_ready = 4'b0001;
    #1;
    check_eq("bc_c1_ready", 32'(b4.in_ready), 32'h0);
    tick();
    check_eq("bc_c1_valid", 32'(b4.out_valid), 32'hE);
    b4.out_ready = 4'b1000;
    #1;
    check_eq("bc_c2_ready", 32'(b4.in_ready), 32'h0);
    tick();
    check_eq("bc_c2_valid", 32'(b4.out_valid), 32'h6);
    b4.out_ready = 4'b0000;
    #1;
    check_eq("bc_c3_ready", 32'(b4.in_ready), 32'h0);
    tick();
    check_eq("bc_c3_valid", 32'(b4.out_valid), 32'h6);
    check_eq("bc_c3_data",  32'(b4.out_data),  32'h3C);
    b4.out_ready = 4'b0110;
    #1;
    check_eq("bc_c4_ready", 32'(b4.in_ready), 32'h1);
    tick();
    check_eq("bc_c4_valid", 32'(b4.out_valid), 32'h0);

    // Async reset in the middle of a broadcast.
    b4.out_ready = 4'b0000;
    b4.in_valid  = 1'b1;
    b4.in_bcast  = 1'b1;
    b4.in_sel    = 2'd0;
    b4.in_data   = 8'h77;
    tick();
    b4.in_valid  = 1'b0;
    b4.in_bcast  = 1'b0;
    b4.out_ready = 4'b1001;
    tick();
    b4.out_ready = 4'b0000;
    check_eq("ar_pre_valid", 32'(b4.out_valid), 32'h6);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", 32'(b4.out_valid), 32'h0);
    check_eq("ar_busy",  32'(b4.busy),      32'h0);
    check_eq("ar_ready", 32'(b4.in_ready),  32'h1);
    check_eq("ar_data",  32'(b4.out_data),  32'h0);
    rst = 1'b0;
    b4.out_ready = 4'b1111;
    b4.in_valid  = 1'b1;
    b4.in_sel    = 2'd1;
    b4.in_data   = 8'h5A;
    tick();
    check_eq("ar_next_valid", 32'(b4.out_valid), 32'h2);
    check_eq("ar_next_data",  32'(b4.out_data),  32'h5A);
    b4.in_valid = 1'b0;
    tick();
    check_eq("ar_next_drain", 32'(b4.out_valid), 32'h0);

    // Three channels: last legal select, then out-of-range drops until saturation.
    b3.out_ready = 3'b000;
    b3.in_valid  = 1'b1;
    b3.in_sel    = 2'd2;
    b3.in_data   = 8'h9D;
    tick();
    check_eq("n3_sel2_valid", 32'(b3.out_valid), 32'h4);
    check_eq("n3_sel2_data",  32'(b3.out_data),  32'h9D);
    b3.out_ready = 3'b111;
    b3.in_sel    = 2'd3;
    b3.in_data   = 8'hEE;
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_cnt < 255) exp_cnt++;
      check_eq("drop_pulse", 32'(b3.drop_pulse), 32'h1);
      check_eq("drop_pend",  32'(b3.out_valid),  32'h0);
      check_eq("drop_cnt",   32'(b3.drop_cnt),   32'(exp_cnt));
    end
    check_eq("drop_data_kept", 32'(b3.out_data), 32'h9D);
    b3.in_valid = 1'b0;
    tick();
    check_eq("drop_pulse_off", 32'(b3.drop_pulse), 32'h0);
    check_eq("drop_cnt_sat",   32'(b3.drop_cnt),   32'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
